// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin arbiter of three requesters onto one time-paced PSRAM controller
module mem_arbiter #(
    parameter int INIT_WAIT  = 8448,
    parameter int WR_HOLD    = 32,
    parameter int RD_GAP     = 8,
    parameter int RD_TIMEOUT = 255
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [2:0]   req_read_i,
    input  logic [2:0]   req_write_i,
    input  logic [59:0]  req_addr_i,
    input  logic [191:0] req_wrdata_i,
    output logic [2:0]   req_ack_o,
    output logic [2:0]   rsp_valid_o,
    output logic [63:0]  rsp_rddata_o,
    output logic         rsp_err_o,
    output logic [19:0]  mem_addr_o,
    output logic         mem_read_o,
    output logic         mem_write_o,
    output logic [63:0]  mem_wrdata_o,
    input  logic         mem_ready_i,
    input  logic [31:0]  mem_rddata_i
);
    typedef enum logic [2:0] {INIT, IDLE, ISSUE, RD_BEAT1, RD_BEAT2, RESP, HOLD} state_t;
    localparam logic [13:0] INIT_W = 14'(INIT_WAIT);
    localparam logic [13:0] WR_H   = 14'(WR_HOLD);
    localparam logic [13:0] RD_G   = 14'(RD_GAP);
    localparam logic [13:0] RD_T   = 14'(RD_TIMEOUT);
    state_t      state_q, state_d;
    logic [13:0] cnt_q, cnt_d, dec;
    logic [1:0]  last_q, last_d, id_q, id_d, p0, p1, p2, win;
    logic        rd_q, rd_d, err_q, err_d, rerr_q, done;
    logic [19:0] addr_q, addr_d;
    logic [63:0] wdata_q, wdata_d, rdata_q;
    logic [31:0] hi_q, hi_d, lo_q, lo_d;
    logic [2:0]  req;
    function automatic logic [1:0] nxt(input logic [1:0] x);
        return (x == 2'd2) ? 2'd0 : x + 2'd1;
    endfunction
    assign req  = req_read_i | req_write_i;
    assign p0   = nxt(last_q);
    assign p1   = nxt(p0);
    assign p2   = nxt(p1);
    assign win  = req[p0] ? p0 : req[p1] ? p1 : p2;
    // a load of 0 or 1 both last one cycle; the counter never wraps
    assign done = cnt_q <= 14'd1;
    assign dec  = (cnt_q == 14'd0) ? 14'd0 : cnt_q - 14'd1;
    assign req_ack_o    = (state_q == ISSUE) ? (3'b001 << id_q) : 3'b000;
    assign rsp_valid_o  = (state_q == RESP) ? (3'b001 << id_q) : 3'b000;
    assign mem_read_o   = (state_q == ISSUE) && rd_q;
    assign mem_write_o  = (state_q == ISSUE) && !rd_q;
    assign mem_addr_o   = addr_q;
    assign mem_wrdata_o = wdata_q;
    assign rsp_rddata_o = rdata_q;
    assign rsp_err_o    = rerr_q;
    // next-state: arbitration, command issue, beat capture and idle pacing
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        last_d  = last_q;
        id_d    = id_q;
        rd_d    = rd_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        err_d   = err_q;
        case (state_q)
            INIT: begin
                state_d = done ? IDLE : INIT;
                cnt_d   = dec;
            end
            IDLE: if (|req) begin
                state_d = ISSUE;
                id_d    = win;
                last_d  = win;
                rd_d    = req_read_i[win];
                addr_d  = req_addr_i[20*win +: 20];
                wdata_d = req_wrdata_i[64*win +: 64];
            end
            ISSUE: begin
                state_d = rd_q ? RD_BEAT1 : HOLD;
                cnt_d   = rd_q ? RD_T : WR_H;
                err_d   = 1'b0;
            end
            RD_BEAT1: begin
                cnt_d = dec;
                if (mem_ready_i) begin
                    hi_d    = mem_rddata_i;
                    state_d = RD_BEAT2;
                end else if (done) begin
                    err_d   = 1'b1;
                    state_d = RESP;
                end
            end
            RD_BEAT2: begin
                cnt_d = dec;
                if (mem_ready_i) begin
                    lo_d    = mem_rddata_i;
                    state_d = RESP;
                end else if (done) begin
                    err_d   = 1'b1;
                    state_d = RESP;
                end
            end
            RESP: begin
                state_d = HOLD;
                cnt_d   = RD_G;
            end
            HOLD: begin
                state_d = done ? IDLE : HOLD;
                cnt_d   = dec;
            end
            default: begin
                state_d = INIT;
                cnt_d   = INIT_W;
            end
        endcase
    end
    // state registers; the response data is captured on entry to RESP so it holds until the next response
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= INIT;
            cnt_q   <= INIT_W;
            last_q  <= 2'd2;
            id_q    <= 2'd0;
            rd_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            err_q   <= 1'b0;
            rdata_q <= '0;
            rerr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            last_q  <= last_d;
            id_q    <= id_d;
            rd_q    <= rd_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            err_q   <= err_d;
            if (state_d == RESP) begin
                rdata_q <= {hi_d, lo_d};
                rerr_q  <= err_d;
            end
        end
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed checks of init gating, read assembly, timeout, round-robin and reset
module tb_mem_arbiter;
    logic         clk = 1'b0;
    logic         rst;
    logic [2:0]   req_read, req_write, req_ack, rsp_valid;
    logic [59:0]  req_addr;
    logic [191:0] req_wrdata;
    logic [63:0]  rsp_rddata, mem_wrdata;
    logic         rsp_err, mem_read, mem_write, mem_ready;
    logic [19:0]  mem_addr;
    logic [31:0]  mem_rddata;
    int vectors = 0;
    int errs = 0;
    int cyc = 0;
    int t0, prev, wc;
    logic [19:0] exp_addr [3];
    logic [63:0] exp_wd [3];
    int order [6];

    mem_arbiter dut (
        .clk(clk), .rst(rst),
        .req_read_i(req_read), .req_write_i(req_write),
        .req_addr_i(req_addr), .req_wrdata_i(req_wrdata),
        .req_ack_o(req_ack), .rsp_valid_o(rsp_valid),
        .rsp_rddata_o(rsp_rddata), .rsp_err_o(rsp_err),
        .mem_addr_o(mem_addr), .mem_read_o(mem_read), .mem_write_o(mem_write),
        .mem_wrdata_o(mem_wrdata), .mem_ready_i(mem_ready), .mem_rddata_i(mem_rddata)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_cmd(input int lim);
        int n = 0;
        while (!(mem_read || mem_write) && n < lim) begin
            tick();
            n++;
        end
        chk("cmd_wait_bound", (n < lim) ? 64'd1 : 64'd0, 64'd1);
    endtask

    task automatic wait_rsp(input int lim);
        int n = 0;
        while (rsp_valid == 3'b000 && n < lim) begin
            tick();
            n++;
        end
        chk("rsp_wait_bound", (n < lim) ? 64'd1 : 64'd0, 64'd1);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_ack"}, 64'(req_ack), 64'd0);
        chk({tag, "_rsp_valid"}, 64'(rsp_valid), 64'd0);
        chk({tag, "_rddata"}, rsp_rddata, 64'd0);
        chk({tag, "_err"}, 64'(rsp_err), 64'd0);
        chk({tag, "_mem_read"}, 64'(mem_read), 64'd0);
        chk({tag, "_mem_write"}, 64'(mem_write), 64'd0);
        chk({tag, "_mem_addr"}, 64'(mem_addr), 64'd0);
        chk({tag, "_mem_wrdata"}, mem_wrdata, 64'd0);
    endtask

    initial begin
        exp_addr = '{20'hA0000, 20'h12345, 20'hA2222};
        exp_wd   = '{64'h0000_0000_BBBB_0000, 64'h1111_1111_BBBB_0001, 64'h2222_2222_BBBB_0002};
        order    = '{2, 0, 1, 2, 0, 1};
        req_addr   = {exp_addr[2], exp_addr[1], exp_addr[0]};
        req_wrdata = {exp_wd[2], exp_wd[1], exp_wd[0]};
        rst = 1'b1; req_read = 3'b000; req_write = 3'b000; mem_ready = 1'b0; mem_rddata = '0;
        tick();
        tick();
        chk_zero("reset");
        // init gating: everyone reads from cycle 0, port 0 wins at INIT_WAIT+1
        t0 = cyc;
        rst = 1'b0;
        req_read = 3'b111;
        wait_cmd(20000);
        chk("init_latency", 64'(cyc - t0), 64'd8449);
        chk("init_mem_read", 64'(mem_read), 64'd1);
        chk("init_ack", 64'(req_ack), 64'b001);
        chk("init_addr", 64'(mem_addr), 64'(exp_addr[0]));
        // timeout: only one beat returned
        t0 = cyc;
        req_read = 3'b010;
        tick();
        mem_ready = 1'b1; mem_rddata = 32'hAAAA5555;
        tick();
        mem_ready = 1'b0;
        wait_rsp(400);
        chk("to_latency", 64'(cyc - t0), 64'd256);
        chk("to_valid", 64'(rsp_valid), 64'b001);
        chk("to_err", 64'(rsp_err), 64'd1);
        chk("to_data", rsp_rddata, 64'hAAAA5555_00000000);
        // next request served after the read gap
        t0 = cyc;
        wait_cmd(50);
        chk("gap_latency", 64'(cyc - t0), 64'd10);
        chk("rd1_ack", 64'(req_ack), 64'b010);
        chk("rd1_mem_read", 64'(mem_read), 64'd1);
        chk("rd1_addr", 64'(mem_addr), 64'h12345);
        // read assembly on port 1
        req_read = 3'b000;
        tick();
        mem_ready = 1'b1; mem_rddata = 32'hDEADBEEF;
        tick();
        mem_ready = 1'b0;
        tick();
        tick();
        mem_ready = 1'b1; mem_rddata = 32'h01234567;
        tick();
        mem_ready = 1'b0;
        chk("rd1_valid", 64'(rsp_valid), 64'b010);
        chk("rd1_data", rsp_rddata, 64'hDEADBEEF_01234567);
        chk("rd1_err", 64'(rsp_err), 64'd0);
        tick();
        chk("rd1_valid_pulse", 64'(rsp_valid), 64'd0);
        chk("rd1_data_held", rsp_rddata, 64'hDEADBEEF_01234567);
        mem_ready = 1'b1; mem_rddata = 32'hFFFFFFFF;
        tick();
        mem_ready = 1'b0;
        // round-robin: last grant was port 1, so order starts at port 2
        req_write = 3'b111;
        prev = 0;
        for (int i = 0; i < 6; i++) begin
            wait_cmd(100);
            chk("rr_mem_write", 64'(mem_write), 64'd1);
            chk("rr_mem_read", 64'(mem_read), 64'd0);
            chk("rr_ack", 64'(req_ack), 64'(3'b001 << order[i]));
            chk("rr_wrdata", mem_wrdata, exp_wd[order[i]]);
            chk("rr_addr", 64'(mem_addr), 64'(exp_addr[order[i]]));
            if (i > 0) chk("rr_spacing", 64'(cyc - prev), 64'd34);
            prev = cyc;
            if (i == 5) req_write = 3'b000;
            tick();
        end
        // read+write together on port 2 is a read
        req_read = 3'b100; req_write = 3'b100;
        wait_cmd(100);
        chk("rw_mem_read", 64'(mem_read), 64'd1);
        chk("rw_mem_write", 64'(mem_write), 64'd0);
        chk("rw_ack", 64'(req_ack), 64'b100);
        chk("rw_addr", 64'(mem_addr), 64'(exp_addr[2]));
        req_read = 3'b000; req_write = 3'b000;
        tick();
        mem_ready = 1'b1; mem_rddata = 32'h13579BDF;
        tick();
        mem_rddata = 32'h2468ACE0;
        tick();
        mem_ready = 1'b0;
        chk("rw_valid", 64'(rsp_valid), 64'b100);
        chk("rw_data", rsp_rddata, 64'h13579BDF_2468ACE0);
        wc = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (mem_write) wc++;
        end
        chk("rw_no_write", 64'(wc), 64'd0);
        // reset in RD_BEAT2 aborts the read and restarts the init wait
        req_read = 3'b001;
        wait_cmd(50);
        chk("rst_rd_ack", 64'(req_ack), 64'b001);
        req_read = 3'b000;
        tick();
        mem_ready = 1'b1; mem_rddata = 32'h55555555;
        tick();
        mem_ready = 1'b0;
        rst = 1'b1;
        tick();
        chk_zero("midrst");
        t0 = cyc;
        rst = 1'b0;
        req_read = 3'b001;
        wait_cmd(20000);
        chk("reinit_latency", 64'(cyc - t0), 64'd8449);
        chk("reinit_ack", 64'(req_ack), 64'b001);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end
endmodule
